mc_ctrl: RTL and testbench

- Multicycle control FSM that sequences the shared 32-bit ALU, register file, PC and unified instruction/data memory of the MIPS-subset core.
- Decodes opcode/funct once per instruction and drives every datapath select, write strobe and the 3-bit ALU operation code.
- Sits between the instruction register and the datapath; it is the only driver of the ALU control input.

---
 rtl/mc_ctrl_pkg.sv | 69 ++++++
 rtl/mc_ctrl_alu_decoder.sv | 35 +++
 rtl/mc_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS-subset control FSM:
//   - state encodings (4-bit, S_FETCH = 0 ... S_BRANCH_NE = 13)
//   - opcode / funct constants
//   - ALU operation codes driven on alu_control
//   - alu_src_b and pc_src select constants
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMRD     = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWR     = 4'd5,
    S_EXEC      = 4'd6,
    S_ALUWB     = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDIEX    = 4'd9,
    S_ADDIWB    = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd12,
    S_BRANCH_NE = 4'd13
  } state_e;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operand B select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Load and store share the address-calculation path
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational R-type funct decoder.
// Ports:
//   funct        in  6  instruction[5:0]
//   alu_control  out 3  ALU operation for the funct (ADD when unsupported)
//   funct_valid  out 1  funct is one of ADD/SUB/AND/OR/XOR/SLT
// ---------------------------------------------------------------------------
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  // funct -> ALU operation lookup
  always_comb begin
    alu_control = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_XOR:  alu_control = ALU_XOR;
      FN_SLT:  alu_control = ALU_SLT;
      default: begin
        alu_control = ALU_ADD;
        funct_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl
// Multicycle control FSM for the MIPS-subset core. Decodes op/funct and
// drives every datapath select, write strobe and the ALU operation code.
// Outputs are combinational from the state register (plus mem_ready gating
// in the memory states) and are all forced to 0 while rst_n is low.
//
// Parameter:
//   MEM_HANDSHAKE  1 = memory states wait for mem_ready, 0 = mem_ready ignored
// Optional feature macro:
//   MC_CTRL_BNE_EN  enables bne (op 000101) via the BRANCH_NE state;
//                   when undefined bne decodes as illegal.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   op, funct, zero, mem_ready instruction fields, ALU zero, memory done
//   mem_read, mem_write, iord  memory control
//   ir_write, pc_write, branch, pc_en, pc_src   IR / PC control
//   reg_write, reg_dst, mem_to_reg              register file control
//   alu_src_a, alu_src_b, alu_control           ALU control
//   illegal                    sticky illegal-instruction flag
//   state_o                    current state for debug
// ---------------------------------------------------------------------------
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       pc_en,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_e     state_q, state_d;
  logic       ready_s;
  logic [2:0] dec_alu_s;
  logic       dec_valid_s;

  logic       mem_read_s, mem_write_s, iord_s, ir_write_s, pc_write_s;
  logic       branch_s, branch_ne_s, reg_write_s, reg_dst_s, mem_to_reg_s;
  logic       alu_src_a_s, illegal_s;
  logic [1:0] alu_src_b_s, pc_src_s;
  logic [2:0] alu_control_s;

  assign ready_s = MEM_HANDSHAKE ? mem_ready : 1'b1;

  alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_control (dec_alu_s),
    .funct_valid (dec_valid_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d       = state_q;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    iord_s        = 1'b0;
    ir_write_s    = 1'b0;
    pc_write_s    = 1'b0;
    branch_s      = 1'b0;
    branch_ne_s   = 1'b0;
    reg_write_s   = 1'b0;
    reg_dst_s     = 1'b0;
    mem_to_reg_s  = 1'b0;
    alu_src_a_s   = 1'b0;
    alu_src_b_s   = SRCB_B;
    pc_src_s      = PCSRC_ALU;
    alu_control_s = ALU_ADD;
    illegal_s     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_s    = 1'b1;
        alu_src_b_s   = SRCB_FOUR;
        alu_control_s = ALU_ADD;
        pc_src_s      = PCSRC_ALU;
        // IR load and PC+4 commit only once the instruction word is back
        if (ready_s) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d    = S_FETCH;
        end
      end
      S_DECODE: begin
        // Speculatively compute branch target into ALUOut
        alu_src_b_s   = SRCB_IMM_SH;
        alu_control_s = ALU_ADD;
        if (is_mem_op(op)) begin
          state_d = S_MEMADR;
        end else begin
          case (op)
            OP_RTYPE: state_d = S_EXEC;
            OP_BEQ:   state_d = S_BRANCH;
            OP_ADDI:  state_d = S_ADDIEX;
            OP_J:     state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
            OP_BNE:   state_d = S_BRANCH_NE;
`endif
            default:  state_d = S_ILLEGAL;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a_s   = 1'b1;
        alu_src_b_s   = SRCB_IMM;
        alu_control_s = ALU_ADD;
        if (op == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
        if (ready_s) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        iord_s = 1'b1;
        // Single write pulse, coincident with the accepting cycle
        if (ready_s) begin
          mem_write_s = 1'b1;
          state_d     = S_FETCH;
        end else begin
          state_d     = S_MEMWR;
        end
      end
      S_EXEC: begin
        alu_src_a_s   = 1'b1;
        alu_src_b_s   = SRCB_B;
        alu_control_s = dec_alu_s;
        if (dec_valid_s) begin
          state_d = S_ALUWB;
        end else begin
          state_d = S_ILLEGAL;
        end
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s   = 1'b1;
        alu_control_s = ALU_SUB;
        branch_s      = 1'b1;
        pc_src_s      = PCSRC_ALUOUT;
        state_d       = S_FETCH;
      end
`ifdef MC_CTRL_BNE_EN
      S_BRANCH_NE: begin
        alu_src_a_s   = 1'b1;
        alu_control_s = ALU_SUB;
        branch_ne_s   = 1'b1;
        pc_src_s      = PCSRC_ALUOUT;
        state_d       = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        alu_src_a_s   = 1'b1;
        alu_src_b_s   = SRCB_IMM;
        alu_control_s = ALU_ADD;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_s = 1'b1;
        pc_src_s   = PCSRC_JUMP;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
        // Trap: no strobes, only reset leaves this state
        illegal_s = 1'b1;
        state_d   = S_ILLEGAL;
      end
      default: begin
        // Unused encodings recover to a clean fetch
        state_d = S_FETCH;
      end
    endcase
  end

  // Every output is held at 0 while reset is asserted
  assign mem_read    = mem_read_s   & rst_n;
  assign mem_write   = mem_write_s  & rst_n;
  assign iord        = iord_s       & rst_n;
  assign ir_write    = ir_write_s   & rst_n;
  assign pc_write    = pc_write_s   & rst_n;
  assign branch      = branch_s     & rst_n;
  assign pc_en       = (pc_write_s | (branch_s & zero) | (branch_ne_s & ~zero)) & rst_n;
  assign reg_write   = reg_write_s  & rst_n;
  assign reg_dst     = reg_dst_s    & rst_n;
  assign mem_to_reg  = mem_to_reg_s & rst_n;
  assign alu_src_a   = alu_src_a_s  & rst_n;
  assign alu_src_b   = alu_src_b_s  & {2{rst_n}};
  assign pc_src      = pc_src_s     & {2{rst_n}};
  assign alu_control = alu_control_s & {3{rst_n}};
  assign illegal     = illegal_s    & rst_n;
  assign state_o     = state_q      & {4{rst_n}};

endmodule

// File: tb/tb_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl
// Scoreboard bench for mc_ctrl: the stimulus thread drives one cycle of
// inputs and queues the hand-derived expected outputs for that cycle; a
// monitor on the falling edge pops and compares. Select outputs are
// compared under a per-state mask; strobes and state are always compared.
// Honours MC_CTRL_BNE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write, branch, pc_en;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .pc_en(pc_en), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_control(alu_control), .illegal(illegal),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Strobe vector bits: {mem_read, mem_write, ir_write, pc_write, branch, pc_en, reg_write, illegal}
  localparam logic [7:0] MR = 8'h80, MW = 8'h40, IRW = 8'h20, PCW = 8'h10;
  localparam logic [7:0] BR = 8'h08, PCE = 8'h04, RW = 8'h02, ILL = 8'h01;

  // Select vector bits: {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], pc_src[1:0], 0, alu_control[2:0]}
  function automatic logic [11:0] sv(input logic io, input logic rd, input logic m2r, input logic a,
                                     input logic [1:0] b, input logic [1:0] pcs, input logic [2:0] alu);
    return {io, rd, m2r, a, b, pcs, 1'b0, alu};
  endfunction

  localparam logic [11:0] M_FETCH = 12'b1001_1111_0111;
  localparam logic [11:0] M_ALUAB = 12'b0001_1100_0111;
  localparam logic [11:0] M_AB    = 12'b0001_1100_0000;
  localparam logic [11:0] M_IORD  = 12'b1000_0000_0000;
  localparam logic [11:0] M_WB    = 12'b0110_0000_0000;
  localparam logic [11:0] M_BR    = 12'b0001_1111_0111;
  localparam logic [11:0] M_PCS   = 12'b0000_0011_0000;
  localparam logic [11:0] M_ALL   = 12'b1111_1111_0111;

  typedef struct {
    string      nm;
    logic [3:0] st;
    logic [7:0] stb;
    logic [11:0] v;
    logic [11:0] m;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Queue the expectation for the current cycle, then advance one clock
  task automatic issue(input string nm, input logic [3:0] st, input logic [7:0] stb,
                       input logic [11:0] v, input logic [11:0] m);
    exp_t e;
    e.nm = nm; e.st = st; e.stb = stb; e.v = v; e.m = m;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_go();
    mem_ready = 1'b1;
    issue("fetch", 4'd0, MR | IRW | PCW | PCE, sv(0,0,0,0,2'b01,2'b00,3'b010), M_FETCH);
  endtask

  task automatic decode();
    issue("decode", 4'd1, 8'h00, sv(0,0,0,0,2'b11,2'b00,3'b010), M_ALUAB);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation
  always @(negedge clk) begin
    logic [7:0]  a_stb;
    logic [11:0] a_sv;
    exp_t        e;
    cyc++;
    if (q.size() > 0) begin
      e     = q.pop_front();
      a_stb = {mem_read, mem_write, ir_write, pc_write, branch, pc_en, reg_write, illegal};
      a_sv  = {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, 1'b0, alu_control};
      tests++;
      if (state_o !== e.st || a_stb !== e.stb || ((a_sv ^ e.v) & e.m) !== 12'h000) begin
        fails++;
        $display("FAIL %s @cyc %0d: got state=%0d strobes=%b sel=%b, need state=%0d strobes=%b sel=%b (mask %b)",
                 e.nm, cyc, state_o, a_stb, a_sv, e.st, e.stb, e.v, e.m);
      end
    end
  end

  typedef struct { logic [5:0] fn; logic [2:0] alu; } rt_t;
  rt_t rt_tab[5];

  initial begin
    rt_tab[0] = '{6'b100000, 3'b010};
    rt_tab[1] = '{6'b100100, 3'b000};
    rt_tab[2] = '{6'b100101, 3'b001};
    rt_tab[3] = '{6'b100110, 3'b011};
    rt_tab[4] = '{6'b101010, 3'b111};

    rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    issue("reset_state", 4'd0, 8'h00, 12'h000, M_ALL);
    rst_n = 1'b1;

    // lw: 2 wait cycles in FETCH, 1 in MEMRD -> 8 cycles
    op = 6'b100011;
    mem_ready = 1'b0;
    issue("lw_fetch_wait", 4'd0, MR, sv(0,0,0,0,2'b01,2'b00,3'b010), M_FETCH);
    issue("lw_fetch_wait", 4'd0, MR, sv(0,0,0,0,2'b01,2'b00,3'b010), M_FETCH);
    fetch_go();
    decode();
    issue("lw_memadr", 4'd2, 8'h00, sv(0,0,0,1,2'b10,2'b00,3'b010), M_ALUAB);
    mem_ready = 1'b0;
    issue("lw_memrd_wait", 4'd3, MR, sv(1,0,0,0,2'b00,2'b00,3'b000), M_IORD);
    mem_ready = 1'b1;
    issue("lw_memrd", 4'd3, MR, sv(1,0,0,0,2'b00,2'b00,3'b000), M_IORD);
    issue("lw_memwb", 4'd4, RW, sv(0,0,1,0,2'b00,2'b00,3'b000), M_WB);

    // R-type sub
    op = 6'b000000; funct = 6'b100010;
    fetch_go();
    decode();
    issue("sub_exec", 4'd6, 8'h00, sv(0,0,0,1,2'b00,2'b00,3'b110), M_ALUAB);
    issue("sub_aluwb", 4'd7, RW, sv(0,1,0,0,2'b00,2'b00,3'b000), M_WB);

    // Remaining R-type functs
    foreach (rt_tab[i]) begin
      funct = rt_tab[i].fn;
      fetch_go();
      decode();
      issue("rtype_exec", 4'd6, 8'h00, sv(0,0,0,1,2'b00,2'b00,rt_tab[i].alu), M_ALUAB);
      issue("rtype_aluwb", 4'd7, RW, sv(0,1,0,0,2'b00,2'b00,3'b000), M_WB);
    end

    // beq taken / not taken
    op = 6'b000100; funct = 6'd0;
    fetch_go();
    decode();
    zero = 1'b1;
    issue("beq_taken", 4'd8, BR | PCE, sv(0,0,0,1,2'b00,2'b01,3'b110), M_BR);
    zero = 1'b0;
    fetch_go();
    decode();
    issue("beq_not_taken", 4'd8, BR, sv(0,0,0,1,2'b00,2'b01,3'b110), M_BR);

    // addi
    op = 6'b001000;
    fetch_go();
    decode();
    issue("addi_ex", 4'd9, 8'h00, sv(0,0,0,1,2'b10,2'b00,3'b010), M_ALUAB);
    issue("addi_wb", 4'd10, RW, sv(0,0,0,0,2'b00,2'b00,3'b000), M_WB);

    // j
    op = 6'b000010;
    fetch_go();
    decode();
    issue("jump", 4'd11, PCW | PCE, sv(0,0,0,0,2'b00,2'b10,3'b000), M_PCS);

    // sw with 3 wait cycles in MEMWR
    op = 6'b101011;
    fetch_go();
    decode();
    issue("sw_memadr", 4'd2, 8'h00, sv(0,0,0,1,2'b10,2'b00,3'b010), M_ALUAB);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue("sw_memwr_wait", 4'd5, 8'h00, sv(1,0,0,0,2'b00,2'b00,3'b000), M_IORD);
    end
    mem_ready = 1'b1;
    issue("sw_memwr", 4'd5, MW, sv(1,0,0,0,2'b00,2'b00,3'b000), M_IORD);

    // Reset mid-MEMRD
    op = 6'b100011;
    fetch_go();
    decode();
    issue("rst_memadr", 4'd2, 8'h00, sv(0,0,0,1,2'b10,2'b00,3'b010), M_ALUAB);
    mem_ready = 1'b0;
    issue("rst_memrd", 4'd3, MR, sv(1,0,0,0,2'b00,2'b00,3'b000), M_IORD);
    rst_n = 1'b0;
    issue("rst_forced_zero", 4'd0, 8'h00, 12'h000, M_ALL);
    rst_n = 1'b1;
    issue("rst_release_fetch", 4'd0, MR, sv(0,0,0,0,2'b01,2'b00,3'b010), M_FETCH);

    // Illegal funct: no register write, sticky illegal
    op = 6'b000000; funct = 6'b000111;
    fetch_go();
    decode();
    issue("badfn_exec", 4'd6, 8'h00, sv(0,0,0,1,2'b00,2'b00,3'b000), M_AB);
    issue("badfn_illegal", 4'd12, ILL, 12'h000, 12'h000);
    issue("badfn_illegal_hold", 4'd12, ILL, 12'h000, 12'h000);
    rst_n = 1'b0;
    issue("badfn_reset", 4'd0, 8'h00, 12'h000, M_ALL);
    rst_n = 1'b1;

    // bne (op 000101)
    op = 6'b000101; funct = 6'd0; zero = 1'b0;
    fetch_go();
    decode();
`ifdef MC_CTRL_BNE_EN
    issue("bne_taken", 4'd13, PCE, sv(0,0,0,1,2'b00,2'b01,3'b110), M_BR);
    zero = 1'b1;
    fetch_go();
    decode();
    issue("bne_not_taken", 4'd13, 8'h00, sv(0,0,0,1,2'b00,2'b01,3'b110), M_BR);
    zero = 1'b0;
    fetch_go();
`else
    issue("bne_illegal", 4'd12, ILL, 12'h000, 12'h000);
    issue("bne_illegal_hold", 4'd12, ILL, 12'h000, 12'h000);
    rst_n = 1'b0;
    issue("bne_reset", 4'd0, 8'h00, 12'h000, M_ALL);
    rst_n = 1'b1;
    fetch_go();
`endif

    // Let the monitor drain the last expectation
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries, need 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
